// File: rtl/piso_stream.sv
`default_nettype none
// =============================================================================
// Module   : piso_stream
// Brief    : Parallel-in / serial-out vector buffer. Loads a DEPTH-element
//            vector in one handshake and streams it LANES elements per beat.
//            Optional shadow buffer for back-to-back vectors: PISO_STREAM_DBUF_EN
// Revision : 1.0 - initial release
// =============================================================================
module piso_stream #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 1024,
  parameter int LANES = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DEPTH*WIDTH-1:0]       in_data,
  input  logic [$clog2(DEPTH+1)-1:0]   in_len,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*WIDTH-1:0]       out_data,
  output logic [LANES-1:0]             out_keep,
  output logic                         out_last,
  output logic                         busy
);

  localparam int BEATS  = DEPTH / LANES;
  localparam int BEAT_W = LANES * WIDTH;
  localparam int LEN_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                        r_state, w_state_nxt;
  logic [PTR_W-1:0]              r_ptr, w_ptr_nxt;
  logic [PTR_W-1:0]              r_last;
  logic [LEN_W-1:0]              r_len;
  logic [BEATS-1:0][BEAT_W-1:0]  r_buf;

  logic [LEN_W-1:0]              w_len_eff;
  logic [PTR_W-1:0]              w_last_eff;
  logic [BEAT_W-1:0]             w_beat_word;
  logic                          w_load;
  logic                          w_beat;
  logic                          w_at_last;
  logic                          w_take_in;

`ifdef PISO_STREAM_DBUF_EN
  logic [BEATS-1:0][BEAT_W-1:0]  r_sh_buf;
  logic [LEN_W-1:0]              r_sh_len;
  logic [PTR_W-1:0]              r_sh_last;
  logic                          r_sh_full;
  logic                          w_take_sh;
  logic                          w_fill_sh;

  assign in_ready = !r_sh_full;
`else
  assign in_ready = (r_state == IDLE);
`endif

  // Zero or oversize length means a full vector.
  always_comb begin
    w_len_eff = in_len;
    if (in_len == '0 || int'(in_len) > DEPTH) w_len_eff = LEN_W'(DEPTH);
  end
  assign w_last_eff = PTR_W'((int'(w_len_eff) - 1) / LANES);

  assign w_load    = in_valid && in_ready;
  assign w_beat    = out_valid && out_ready;
  assign w_at_last = (r_ptr == r_last);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_take_in   = 1'b0;
`ifdef PISO_STREAM_DBUF_EN
    w_take_sh   = 1'b0;
    w_fill_sh   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_load) begin
          w_state_nxt = STREAM;
          w_ptr_nxt   = '0;
          w_take_in   = 1'b1;
        end
      end
      STREAM: begin
        if (w_beat && !w_at_last) begin
          w_ptr_nxt = r_ptr + 1'b1;
        end else if (w_beat) begin
          w_ptr_nxt = '0;
`ifdef PISO_STREAM_DBUF_EN
          // Promote the shadow, or take a coincident load straight to active.
          if (r_sh_full)   w_take_sh   = 1'b1;
          else if (w_load) w_take_in   = 1'b1;
          else             w_state_nxt = IDLE;
`else
          w_state_nxt = IDLE;
`endif
        end
`ifdef PISO_STREAM_DBUF_EN
        if (w_load && !(w_beat && w_at_last)) w_fill_sh = 1'b1;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_last  <= '0;
      r_len   <= '0;
      r_buf   <= '0;
`ifdef PISO_STREAM_DBUF_EN
      r_sh_buf  <= '0;
      r_sh_len  <= '0;
      r_sh_last <= '0;
      r_sh_full <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      if (w_take_in) begin
        r_buf  <= in_data;
        r_len  <= w_len_eff;
        r_last <= w_last_eff;
      end
`ifdef PISO_STREAM_DBUF_EN
      else if (w_take_sh) begin
        r_buf  <= r_sh_buf;
        r_len  <= r_sh_len;
        r_last <= r_sh_last;
      end
      if (w_fill_sh) begin
        r_sh_buf  <= in_data;
        r_sh_len  <= w_len_eff;
        r_sh_last <= w_last_eff;
        r_sh_full <= 1'b1;
      end else if (w_take_sh) begin
        r_sh_full <= 1'b0;
      end
`endif
    end
  end

  assign w_beat_word = r_buf[r_ptr];
  assign out_valid   = (r_state == STREAM);
  assign busy        = (r_state == STREAM);
  assign out_last    = (r_state == STREAM) && w_at_last;

  always_comb begin
    out_data = '0;
    out_keep = '0;
    if (r_state == STREAM) begin
      for (int i = 0; i < LANES; i++) begin
        if (int'(r_ptr) * LANES + i < int'(r_len)) begin
          out_keep[i]                = 1'b1;
          out_data[i*WIDTH +: WIDTH] = w_beat_word[i*WIDTH +: WIDTH];
        end
      end
    end
  end

endmodule
`default_nettype wire
